sisc_ifetch: RTL and testbench
==============================

# sisc_ifetch

Instruction fetch stage for the SISC processor. Holds the program counter (PC) and instruction register (IR), fetches from instruction memory over a req/ack handshake, and applies branch updates. It sits directly upstream of the control FSM: IR[31:28] drives the control unit's `opcode` input and IR[27:24] drives its `mm` input. The control FSM commands fetches and branches; the status register supplies `stat`.

## Interface
Parameters:
- `ADDR_W`, 16: PC and instruction-memory address width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk` in 1: system clock, positive edge active.
- `rst` in 1: reset, synchronous, active-high.
- `fetch_req` in 1: one-cycle pulse from control FSM (fetch state); start a fetch.
- `br_en` in 1: one-cycle pulse from control FSM (execute state); evaluate branch for instruction in IR.
- `stat` in 4: status register contents.
- `imem_req` out 1: memory request; held until ack.
- `imem_addr` out ADDR_W: fetch address, equal to the PC while `imem_req` is high.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` in 32: instruction word.
- `ir` out 32: instruction register.
- `opcode` out 4: `ir[31:28]`.
- `mm` out 4: `ir[27:24]`.
- `pc` out ADDR_W: program counter.
- `fetch_done` out 1: one-cycle pulse when IR holds the new instruction.
- `busy` out 1: high in REQ state.
- `br_taken` out 1: one-cycle pulse when a branch updated the PC.

## Operation
- Reset values: `pc`=RESET_PC, `ir`=0 (reads as NOOP), `imem_req`=0, `fetch_done`=0, `busy`=0, `br_taken`=0, state IDLE.
- The FSM has two states, IDLE and REQ.
  - IDLE→REQ on `fetch_req`.
  - REQ→IDLE on `imem_ack`.
- In REQ: `imem_req`=1 and `imem_addr`=`pc`. On the ack edge:
  - `ir` ← `imem_rdata`.
  - `pc` ← `pc`+1, mod 2^ADDR_W.
  - `fetch_done` is high for the next cycle.
- Branch evaluation on `br_en` in IDLE only. The immediate is `ir[15:0]`, zero-extended or truncated to ADDR_W.
  - BRA (4): taken if `mm`==0 or (`stat` & `mm`)≠0; `pc` ← imm.
  - BRR (5): same condition; `pc` ← `pc` + sign-extended `ir[15:0]`, mod 2^ADDR_W. The `pc` operand here is the already-incremented PC.
  - BNE (6): taken if (`stat` & `mm`)==0; `pc` ← imm.
  - BNR (7): same condition as BNE; relative target, as BRR.
  - Any other opcode, or condition false: `pc` unchanged and `br_taken`=0.
- Simultaneous `br_en` and `fetch_req` in IDLE: the branch PC update occurs on that edge. REQ is entered on the same edge, so `imem_addr` shows the branch target.
- `br_en` or `fetch_req` while in REQ: ignored. No queuing.
- `imem_ack` while in IDLE: ignored; `ir` and `pc` unchanged.
- Reset mid-fetch: the request is abandoned. All outputs take reset values after the edge, and a later ack is ignored.
- `ir` changes only on an accepted ack or on reset. `pc` changes only on an accepted ack, a taken branch, or reset.

## Timing
- Edge N: `fetch_req` sampled. From cycle N+1: `imem_req`=1.
- Ack sampled at edge M ≥ N+1: `ir`, `pc` and `fetch_done` update after edge M; `imem_req` is 0 in cycle M+1.
- Zero-wait memory, with ack in the first REQ cycle: the fetch takes 2 cycles from `fetch_req` to `fetch_done`. This fits the control FSM's fetch→decode spacing, so `opcode` and `mm` are valid in decode.
- Branch: the PC update and `br_taken` pulse are visible in the cycle after `br_en`.
- All outputs are registered except `opcode`, `mm` and `imem_addr`, which are wires from registers.

## Structure
- Shared package `sisc_pkg` holds:
  - opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15);
  - the IDLE/REQ state encoding;
  - the instruction field positions.
- One sub-module, `sisc_br_eval`: combinational. Inputs are `opcode`, `mm`, `stat`, `pc` and `imm`; outputs are `take` and `target`.

## Test plan
- Reset, then `fetch_req` with ack in the first REQ cycle and `imem_rdata`=0x81230000 → `imem_addr`=0, `ir`=0x81230000, `opcode`=8, `mm`=1, `pc`=1, one `fetch_done` pulse 2 cycles after the request.
- Ack delayed 3 cycles → `imem_req` held 4 cycles with a stable address; a `fetch_req` during REQ is ignored; `pc` advances by exactly 1.
- `ir`=0x42000010, `pc`=5:
  - `stat`=0x2, `br_en` → `pc`=0x10, `br_taken`=1.
  - `stat`=0x1, `br_en` → `pc`=5, `br_taken`=0.
- `ir`=0x5000FFFE (BRR, `mm`=0), `pc`=3, `br_en` → `pc`=1. With `pc`=0 and offset 0xFFFF → `pc`=0xFFFF (wrap).
- `ir`=0x61000020 (BNE, `mm`=1), `stat`=0, with `br_en` and `fetch_req` asserted together → `pc`=0x20, `imem_addr`=0x20 in the next cycle.
- `rst` asserted mid-REQ, then a stray ack in IDLE → `pc`=RESET_PC, `ir`=0, `imem_req`=0, no `fetch_done`.

Source files
------------

// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared opcodes, fetch state encoding and instruction field positions for SISC
package sisc_pkg;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  localparam int IR_OPCODE_MSB = 31;
  localparam int IR_OPCODE_LSB = 28;
  localparam int IR_MM_MSB     = 27;
  localparam int IR_MM_LSB     = 24;
  localparam int IR_IMM_MSB    = 15;
  localparam int IR_IMM_LSB    = 0;

endpackage

// File: rtl/sisc_br_eval.sv
// rtl/sisc_br_eval.sv - combinational branch condition and target evaluation
module sisc_br_eval
  import sisc_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [3:0]        opcode,
  input  logic [3:0]        mm,
  input  logic [3:0]        stat,
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  output logic              take,
  output logic [ADDR_W-1:0] target
);

  logic              stat_hit;
  logic [ADDR_W-1:0] abs_target;
  logic [ADDR_W-1:0] rel_offset;

  always_comb begin
    stat_hit   = (stat & mm) != 4'h0;
    abs_target = ADDR_W'(imm);
    rel_offset = ADDR_W'($signed(imm));
    take       = 1'b0;
    target     = pc;
    case (opcode)
      OP_BRA: begin
        take   = (mm == 4'h0) || stat_hit;
        target = abs_target;
      end
      OP_BRR: begin
        take   = (mm == 4'h0) || stat_hit;
        target = pc + rel_offset;
      end
      OP_BNE: begin
        take   = !stat_hit;
        target = abs_target;
      end
      OP_BNR: begin
        take   = !stat_hit;
        target = pc + rel_offset;
      end
      default: begin
        take   = 1'b0;
        target = pc;
      end
    endcase
  end

endmodule

// File: rtl/sisc_ifetch.sv
// rtl/sisc_ifetch.sv - SISC instruction fetch stage: PC, IR, memory handshake and branch update
module sisc_ifetch
  import sisc_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              br_en,
  input  logic [3:0]        stat,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_done,
  output logic              busy,
  output logic              br_taken
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              fetch_done_q, fetch_done_d;
  logic              br_taken_q, br_taken_d;

  logic              br_take;
  logic [ADDR_W-1:0] br_target;

  sisc_br_eval #(.ADDR_W(ADDR_W)) u_br_eval (
    .opcode (ir_q[IR_OPCODE_MSB:IR_OPCODE_LSB]),
    .mm     (ir_q[IR_MM_MSB:IR_MM_LSB]),
    .stat   (stat),
    .pc     (pc_q),
    .imm    (ir_q[IR_IMM_MSB:IR_IMM_LSB]),
    .take   (br_take),
    .target (br_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      fetch_done_q <= 1'b0;
      br_taken_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      fetch_done_q <= fetch_done_d;
      br_taken_q   <= br_taken_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fetch_req) state_d = ST_REQ;
      ST_REQ:  if (imem_ack)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A branch taken alongside fetch_req lands on the same edge, so the new request sees the target.
  always_comb begin
    pc_d         = pc_q;
    ir_d         = ir_q;
    fetch_done_d = 1'b0;
    br_taken_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (br_en && br_take) begin
        pc_d       = br_target;
        br_taken_d = 1'b1;
      end
    end else if (imem_ack) begin
      ir_d         = imem_rdata;
      pc_d         = pc_q + ADDR_W'(1);
      fetch_done_d = 1'b1;
    end
  end

  always_comb begin
    imem_req   = (state_q == ST_REQ);
    busy       = (state_q == ST_REQ);
    imem_addr  = pc_q;
    ir         = ir_q;
    opcode     = ir_q[IR_OPCODE_MSB:IR_OPCODE_LSB];
    mm         = ir_q[IR_MM_MSB:IR_MM_LSB];
    pc         = pc_q;
    fetch_done = fetch_done_q;
    br_taken   = br_taken_q;
  end

endmodule

// File: tb/tb_sisc_ifetch.sv
// tb/tb_sisc_ifetch.sv - randomized self-checking bench for sisc_ifetch against a behavioural model
module tb_sisc_ifetch;

  logic        clk = 1'b0;
  logic        rst, fetch_req, br_en, imem_ack;
  logic [3:0]  stat;
  logic [31:0] imem_rdata;
  logic        imem_req, fetch_done, busy, br_taken;
  logic [15:0] imem_addr, pc;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;

  sisc_ifetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .br_en(br_en), .stat(stat),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .opcode(opcode), .mm(mm), .pc(pc), .fetch_done(fetch_done), .busy(busy),
    .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] ref_pc;
  logic [31:0] ref_ir;
  bit          ref_taken;

  int          rc, fe;
  bit          stable;
  logic [15:0] addr_seen;
  logic        fa, ra, fl;

  // Branch rule straight from the ISA: returns the PC after br_en and whether it was taken.
  function automatic logic [15:0] model_next_pc(input logic [31:0] w, input logic [15:0] cur,
                                                input logic [3:0] st, output bit taken);
    int op, m, off, tmp;
    bit any;
    op  = int'(w[31:28]);
    m   = int'(w[27:24]);
    any = (st & w[27:24]) != 4'h0;
    off = w[15] ? int'(w[15:0]) - 65536 : int'(w[15:0]);
    taken = 1'b0;
    if (op == 4 || op == 5) taken = (m == 0) || any;
    else if (op == 6 || op == 7) taken = !any;
    if (!taken) return cur;
    if (op == 4 || op == 6) return w[15:0];
    tmp = (int'(cur) + off + 65536) % 65536;
    return tmp[15:0];
  endfunction

  task automatic run_fetch(input logic [31:0] word, input int dly, input bit extra_req,
                           output int req_cycles, output bit addr_stable,
                           output logic [15:0] addr0, output logic fd_after,
                           output logic req_after, output logic fd_late, output int fd_early);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req   = 1'b0;
    req_cycles  = 0;
    addr_stable = 1'b1;
    addr0       = imem_addr;
    fd_early    = 0;
    for (int k = 0; k <= dly; k++) begin
      if (imem_req) req_cycles++;
      if (imem_addr !== addr0) addr_stable = 1'b0;
      if (fetch_done) fd_early++;
      if (extra_req) fetch_req = (k == 0);
      if (k == dly) begin
        imem_ack   = 1'b1;
        imem_rdata = word;
      end
      @(negedge clk);
    end
    fetch_req  = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    fd_after   = fetch_done;
    req_after  = imem_req;
    ref_ir     = word;
    ref_pc     = ref_pc + 16'd1;
    @(negedge clk);
    fd_late = fetch_done;
  endtask

  task automatic do_branch(input logic [3:0] st, input bit with_fetch);
    stat      = st;
    br_en     = 1'b1;
    fetch_req = with_fetch;
    ref_pc    = model_next_pc(ref_ir, ref_pc, st, ref_taken);
    @(negedge clk);
    br_en     = 1'b0;
    fetch_req = 1'b0;
  endtask

  task automatic set_pc(input logic [15:0] target);
    run_fetch({16'h4000, target}, 0, 1'b0, rc, stable, addr_seen, fa, ra, fl, fe);
    do_branch(4'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_pc = 16'h0000;
    ref_ir = 32'h0;
    n_total++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", pc); else n_pass++;
    n_total++; if (ir !== 32'h0) $display("FAIL reset_ir: got %h want 0", ir); else n_pass++;
    n_total++; if ({imem_req, fetch_done, busy, br_taken} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {imem_req, fetch_done, busy, br_taken});
    else n_pass++;
  endtask

  task automatic test_basic_fetch();
    run_fetch(32'h81230000, 0, 1'b0, rc, stable, addr_seen, fa, ra, fl, fe);
    n_total++; if (addr_seen !== 16'h0000) $display("FAIL basic_addr: got %h want 0000", addr_seen); else n_pass++;
    n_total++; if (rc !== 1) $display("FAIL basic_req_cycles: got %0d want 1", rc); else n_pass++;
    n_total++; if (ir !== 32'h81230000) $display("FAIL basic_ir: got %h want 81230000", ir); else n_pass++;
    n_total++; if ({opcode, mm} !== 8'h81) $display("FAIL basic_opcode_mm: got %h want 81", {opcode, mm}); else n_pass++;
    n_total++; if (pc !== 16'h0001) $display("FAIL basic_pc: got %h want 0001", pc); else n_pass++;
    n_total++; if ({fe[0], fa, fl, ra} !== 4'b0100)
      $display("FAIL basic_done_pulse: got early/at/late/req=%b want 0100", {fe[0], fa, fl, ra});
    else n_pass++;
  endtask

  task automatic test_delayed_ack();
    logic [31:0] w;
    w = $urandom;
    run_fetch(w, 3, 1'b1, rc, stable, addr_seen, fa, ra, fl, fe);
    n_total++; if (rc !== 4) $display("FAIL delay_req_cycles: got %0d want 4", rc); else n_pass++;
    n_total++; if (!stable || addr_seen !== 16'h0001)
      $display("FAIL delay_addr: got %h stable=%0d want 0001 stable=1", addr_seen, stable);
    else n_pass++;
    n_total++; if (ir !== w) $display("FAIL delay_ir: got %h want %h", ir, w); else n_pass++;
    n_total++; if (pc !== 16'h0002) $display("FAIL delay_pc: got %h want 0002", pc); else n_pass++;
    n_total++; if ({fa, fl, imem_req, busy} !== 4'b1000)
      $display("FAIL delay_extra_req_ignored: got done/late/req/busy=%b want 1000", {fa, fl, imem_req, busy});
    else n_pass++;
  endtask

  task automatic test_bra();
    set_pc(16'h0004);
    run_fetch(32'h42000010, 0, 1'b0, rc, stable, addr_seen, fa, ra, fl, fe);
    n_total++; if (pc !== 16'h0005) $display("FAIL bra_setup_pc: got %h want 0005", pc); else n_pass++;
    do_branch(4'h2, 1'b0);
    n_total++; if (pc !== 16'h0010 || br_taken !== 1'b1)
      $display("FAIL bra_taken: got pc=%h taken=%b want 0010 1", pc, br_taken);
    else n_pass++;
    @(negedge clk);
    n_total++; if (br_taken !== 1'b0) $display("FAIL bra_pulse: got %b want 0", br_taken); else n_pass++;
    set_pc(16'h0004);
    run_fetch(32'h42000010, 0, 1'b0, rc, stable, addr_seen, fa, ra, fl, fe);
    do_branch(4'h1, 1'b0);
    n_total++; if (pc !== 16'h0005 || br_taken !== 1'b0)
      $display("FAIL bra_not_taken: got pc=%h taken=%b want 0005 0", pc, br_taken);
    else n_pass++;
  endtask

  task automatic test_brr_wrap();
    set_pc(16'h0002);
    run_fetch(32'h5000FFFE, 0, 1'b0, rc, stable, addr_seen, fa, ra, fl, fe);
    n_total++; if (pc !== 16'h0003) $display("FAIL brr_setup_pc: got %h want 0003", pc); else n_pass++;
    do_branch($urandom, 1'b0);
    n_total++; if (pc !== 16'h0001 || br_taken !== 1'b1)
      $display("FAIL brr_back: got pc=%h taken=%b want 0001 1", pc, br_taken);
    else n_pass++;
    set_pc(16'hFFFF);
    run_fetch(32'h5000FFFF, 0, 1'b0, rc, stable, addr_seen, fa, ra, fl, fe);
    n_total++; if (pc !== 16'h0000) $display("FAIL pc_incr_wrap: got %h want 0000", pc); else n_pass++;
    do_branch($urandom, 1'b0);
    n_total++; if (pc !== 16'hFFFF) $display("FAIL brr_wrap: got %h want ffff", pc); else n_pass++;
  endtask

  task automatic test_bne_with_fetch();
    logic [31:0] w;
    run_fetch(32'h61000020, 0, 1'b0, rc, stable, addr_seen, fa, ra, fl, fe);
    do_branch(4'h0, 1'b1);
    n_total++; if (pc !== 16'h0020 || imem_addr !== 16'h0020 || imem_req !== 1'b1 || br_taken !== 1'b1)
      $display("FAIL bne_fetch_same_edge: got pc=%h addr=%h req=%b taken=%b want 0020 0020 1 1",
               pc, imem_addr, imem_req, br_taken);
    else n_pass++;
    w = $urandom;
    imem_ack = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0;
    ref_ir = w;
    ref_pc = 16'h0021;
    n_total++; if (pc !== 16'h0021 || ir !== w || fetch_done !== 1'b1)
      $display("FAIL bne_fetch_complete: got pc=%h ir=%h done=%b want 0021 %h 1", pc, ir, fetch_done, w);
    else n_pass++;
  endtask

  task automatic test_br_in_req();
    logic [15:0] p;
    run_fetch(32'h40000ABC, 0, 1'b0, rc, stable, addr_seen, fa, ra, fl, fe);
    p = pc;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    br_en = 1'b1;
    @(negedge clk);
    br_en = 1'b0;
    n_total++; if (pc !== p || br_taken !== 1'b0 || imem_req !== 1'b1)
      $display("FAIL br_in_req_ignored: got pc=%h taken=%b req=%b want %h 0 1", pc, br_taken, imem_req, p);
    else n_pass++;
    imem_ack = 1'b1;
    imem_rdata = 32'h0;
    @(negedge clk);
    imem_ack = 1'b0;
    ref_ir = 32'h0;
    ref_pc = p + 16'd1;
    n_total++; if (pc !== ref_pc) $display("FAIL br_in_req_pc: got %h want %h", pc, ref_pc); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", busy); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (pc !== 16'h0000 || ir !== 32'h0 || imem_req !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstmid_state: got pc=%h ir=%h req=%b busy=%b want 0000 0 0 0", pc, ir, imem_req, busy);
    else n_pass++;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    n_total++; if (pc !== 16'h0000 || ir !== 32'h0 || fetch_done !== 1'b0)
      $display("FAIL rstmid_stray_ack: got pc=%h ir=%h done=%b want 0000 0 0", pc, ir, fetch_done);
    else n_pass++;
    @(negedge clk);
    n_total++; if (fetch_done !== 1'b0) $display("FAIL rstmid_no_done: got %b want 0", fetch_done); else n_pass++;
    ref_pc = 16'h0000;
    ref_ir = 32'h0;
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [3:0]  op, m;
    int          dly;
    for (int i = 0; i < 60; i++) begin
      op  = ($urandom_range(0, 9) < 8) ? 4'(4 + $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      m   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      w   = {op, m, 8'($urandom), 16'($urandom)};
      dly = $urandom_range(0, 3);
      run_fetch(w, dly, 1'($urandom), rc, stable, addr_seen, fa, ra, fl, fe);
      n_total++; if (ir !== ref_ir || pc !== ref_pc || rc !== dly + 1 || fa !== 1'b1 || !stable)
        $display("FAIL rand_fetch[%0d]: got ir=%h pc=%h req=%0d done=%b want %h %h %0d 1",
                 i, ir, pc, rc, fa, ref_ir, ref_pc, dly + 1);
      else n_pass++;
      if ($urandom_range(0, 3) == 0) begin
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        @(negedge clk);
        imem_ack = 1'b0;
        n_total++; if (ir !== ref_ir || pc !== ref_pc || fetch_done !== 1'b0)
          $display("FAIL rand_idle_ack[%0d]: got ir=%h pc=%h want %h %h", i, ir, pc, ref_ir, ref_pc);
        else n_pass++;
      end
      do_branch(4'($urandom), 1'b0);
      n_total++; if (pc !== ref_pc || br_taken !== ref_taken)
        $display("FAIL rand_branch[%0d]: ir=%h got pc=%h taken=%b want %h %b",
                 i, ref_ir, pc, br_taken, ref_pc, ref_taken);
      else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    fetch_req = 1'b0;
    br_en = 1'b0;
    imem_ack = 1'b0;
    stat = 4'h0;
    imem_rdata = 32'h0;
    ref_pc = 16'h0;
    ref_ir = 32'h0;
    ref_taken = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_delayed_ack();
    test_bra();
    test_brr_wrap();
    test_bne_with_fetch();
    test_br_in_req();
    test_reset_mid_fetch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
